// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the instruction-fetch PC sequencer: FSM encoding and
// default reset/increment constants.
package pc_sequencer_pkg;

  localparam int unsigned AddrW      = 32;
  localparam int unsigned InstrBytes = 4;
  localparam logic [31:0] ResetVec   = 32'h0000_0000;

  typedef enum logic [1:0] {
    StBoot = 2'd0,
    StRun  = 2'd1,
    StHold = 2'd2
  } pc_state_e;

  // A redirect target is misaligned when either of its two low bits is set.
  function automatic logic is_misaligned(input logic [1:0] low_bits);
    return low_bits != 2'b00;
  endfunction

endpackage

// File: rtl/pc_sequencer_add_alu.sv
// PC adder: base PC plus either the sequential increment or a branch offset,
// wrapping modulo 2^Width.
module pc_sequencer_add_alu #(
  parameter int unsigned Width = 32
) (
  input  logic [Width-1:0] PCout,
  input  logic [Width-1:0] offset,
  output logic [Width-1:0] increPC
);

  assign increPC = PCout + offset;

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage PC sequencer: owns the PC, holds it on busywait/stall and parks
// redirects that arrive while the PC cannot advance.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int unsigned          ADDR_W      = AddrW,
  parameter logic [ADDR_W-1:0]    RESET_VEC   = ADDR_W'(ResetVec),
  parameter int unsigned          INSTR_BYTES = InstrBytes
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              stall,
  input  logic              imem_busywait,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_offset,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_target,
  output logic [ADDR_W-1:0] pc,
  output logic              fetch_valid,
  output logic              misaligned
);

  pc_state_e         state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              pend_valid_q, pend_valid_d;
  logic [ADDR_W-1:0] pend_value_q, pend_value_d;
  logic              misaligned_q, misaligned_d;

  logic [ADDR_W-1:0] alu_offset, alu_sum, target;
  logic              redirect;

  // One adder serves both the live advance and the capture-time branch target.
  assign alu_offset = branch_taken ? branch_offset : ADDR_W'(INSTR_BYTES);

  pc_sequencer_add_alu #(
    .Width(ADDR_W)
  ) u_add_alu (
    .PCout  (pc_q),
    .offset (alu_offset),
    .increPC(alu_sum)
  );

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pend_valid_d = pend_valid_q;
    pend_value_d = pend_value_q;
    misaligned_d = 1'b0;
    target       = alu_sum;
    redirect     = 1'b0;

    if (pend_valid_q) begin
      target   = pend_value_q;
      redirect = 1'b1;
    end else if (jump) begin
      target   = jump_target;
      redirect = 1'b1;
    end else if (branch_taken) begin
      redirect = 1'b1;
    end

    unique case (state_q)
      StBoot: state_d = StRun;
      StRun, StHold: begin
        if (imem_busywait || stall) begin
          state_d = StHold;
          // Newest redirect wins; a jump beats a branch in the same cycle.
          if (jump) begin
            pend_valid_d = 1'b1;
            pend_value_d = jump_target;
          end else if (branch_taken) begin
            pend_valid_d = 1'b1;
            pend_value_d = alu_sum;
          end
        end else begin
          state_d      = StRun;
          pc_d         = {target[ADDR_W-1:2], 2'b00};
          misaligned_d = redirect && is_misaligned(target[1:0]);
          pend_valid_d = 1'b0;
        end
      end
      default: state_d = StBoot;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= StBoot;
      pc_q         <= RESET_VEC;
      pend_valid_q <= 1'b0;
      pend_value_q <= '0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pend_valid_q <= pend_valid_d;
      pend_value_q <= pend_value_d;
      misaligned_q <= misaligned_d;
    end
  end

  assign pc          = pc_q;
  assign fetch_valid = (state_q != StBoot);
  assign misaligned  = misaligned_q;

endmodule
